// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int DEF_PC_W        = 8;
    localparam int DEF_JT_DEPTH    = 32;
    localparam int DEF_STACK_DEPTH = 4;

    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_SEQ,
        SRC_JUMP,
        SRC_CALL,
        SRC_RET
    } next_src_e;

endpackage

// File: rtl/fetch_seq_if.sv
// Controller-side bundle of the fetch sequencer: requests, jump-table write port, status.
interface fetch_seq_if
    import fetch_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int JT_DEPTH    = DEF_JT_DEPTH,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
);
    localparam int JP_W    = $clog2(JT_DEPTH);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic              Stall;
    logic              Jen;
    logic              Zero;
    logic              Uncond;
    logic              Call;
    logic              Ret;
    logic              Halt;
    logic [JP_W-1:0]   Jptr;
    logic              JtWen;
    logic [JP_W-1:0]   JtWaddr;
    logic [PC_W-1:0]   JtWdat;
    logic [PC_W-1:0]   PC;
    logic              Done;
    logic              StkErr;
    logic [DEPTH_W-1:0] Depth;

    modport master (
        output Stall, Jen, Zero, Uncond, Call, Ret, Halt, Jptr,
        output JtWen, JtWaddr, JtWdat,
        input  PC, Done, StkErr, Depth
    );

    modport slave (
        input  Stall, Jen, Zero, Uncond, Call, Ret, Halt, Jptr,
        input  JtWen, JtWaddr, JtWdat,
        output PC, Done, StkErr, Depth
    );

endinterface

// File: rtl/ret_stack.sv
// Hardware return-address stack; pop wins over push, overflow/underflow reported combinationally.
module ret_stack #(
    parameter  int PC_W        = 8,
    parameter  int STACK_DEPTH = 4,
    localparam int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic [DW-1:0]   depth,
    output logic            ovf,
    output logic            unf
);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0] mem [STACK_DEPTH];
    logic [DW-1:0]   cnt;
    logic            full;
    logic            empty;
    logic            do_push;
    logic            do_pop;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;

    assign full    = (cnt == DW'(STACK_DEPTH));
    assign empty   = (cnt == '0);
    assign ovf     = push & full;
    assign unf     = pop & empty;
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~full & ~pop;
    assign wr_idx  = AW'(cnt);
    assign rd_idx  = AW'(cnt - DW'(1));
    assign top     = empty ? '0 : mem[rd_idx];
    assign depth   = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
        end else if (do_pop) begin
            cnt <= cnt - DW'(1);
        end else if (do_push) begin
            mem[wr_idx] <= din;
            cnt         <= cnt + DW'(1);
        end
    end

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: PC, writable jump table, call/return stack, sticky halt.
// Optional FETCH_REL_JUMP_EN makes table entries signed PC-relative offsets.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int JT_DEPTH    = DEF_JT_DEPTH,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic        Clk,
    input  logic        Reset,
    fetch_seq_if.slave  bus
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] jt [JT_DEPTH];
    logic [PC_W-1:0] top;
    logic [DW-1:0]   depth;
    logic            done;
    logic            stk_err;
    logic            push;
    logic            pop;
    logic            ovf;
    logic            unf;
    logic            set_done;
    next_src_e       src;

    assign pc_inc = pc + PC_W'(1);

`ifdef FETCH_REL_JUMP_EN
    logic signed [PC_W-1:0] jt_off;
    assign jt_off = $signed(jt[bus.Jptr]);
    assign target = PC_W'($signed(pc) + jt_off);
`else
    assign target = jt[bus.Jptr];
`endif

    ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (Clk),
        .rst_n (Reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (top),
        .depth (depth),
        .ovf   (ovf),
        .unf   (unf)
    );

    // Stack errors fall back to sequential fetch; occupancy decides before the stack updates.
    always_comb begin
        src      = SRC_SEQ;
        push     = 1'b0;
        pop      = 1'b0;
        set_done = 1'b0;
        if (done) begin
            src = SRC_HOLD;
        end else if (bus.Halt) begin
            src      = SRC_HOLD;
            set_done = 1'b1;
        end else if (bus.Stall) begin
            src = SRC_HOLD;
        end else if (bus.Ret) begin
            pop = 1'b1;
            src = (depth != '0) ? SRC_RET : SRC_SEQ;
        end else if (bus.Call) begin
            push = 1'b1;
            src  = (depth != DW'(STACK_DEPTH)) ? SRC_CALL : SRC_SEQ;
        end else if (bus.Jen & (bus.Zero | bus.Uncond)) begin
            src = SRC_JUMP;
        end
    end

    always_comb begin
        pc_nxt = pc_inc;
        case (src)
            SRC_HOLD: pc_nxt = pc;
            SRC_SEQ:  pc_nxt = pc_inc;
            SRC_JUMP: pc_nxt = target;
            SRC_CALL: pc_nxt = target;
            SRC_RET:  pc_nxt = top;
            default:  pc_nxt = pc_inc;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc      <= '0;
            done    <= 1'b0;
            stk_err <= 1'b0;
            for (int i = 0; i < JT_DEPTH; i++) jt[i] <= '0;
        end else begin
            pc <= pc_nxt;
            if (set_done)   done    <= 1'b1;
            if (ovf | unf)  stk_err <= 1'b1;
            if (bus.JtWen)  jt[bus.JtWaddr] <= bus.JtWdat;
        end
    end

    assign bus.PC     = pc;
    assign bus.Done   = done;
    assign bus.StkErr = stk_err;
    assign bus.Depth  = depth;

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: directed steps queue expected state, a monitor compares.
module tb_fetch_seq;
    import fetch_pkg::*;

    localparam int PC_W        = 8;
    localparam int JT_DEPTH    = 32;
    localparam int STACK_DEPTH = 4;
    localparam int JP_W        = $clog2(JT_DEPTH);

    localparam logic [6:0] IDLE  = 7'b0000000;
    localparam logic [6:0] STALL = 7'b1000000;
    localparam logic [6:0] JEN   = 7'b0100000;
    localparam logic [6:0] ZERO  = 7'b0010000;
    localparam logic [6:0] UNC   = 7'b0001000;
    localparam logic [6:0] CALL  = 7'b0000100;
    localparam logic [6:0] RET   = 7'b0000010;
    localparam logic [6:0] HALT  = 7'b0000001;

    typedef struct {
        int         cyc;
        string      nm;
        logic [7:0] pc;
        logic       done;
        logic       err;
        logic [2:0] depth;
    } exp_t;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q[$];

    always #5 Clk = ~Clk;

    fetch_seq_if #(.PC_W(PC_W), .JT_DEPTH(JT_DEPTH), .STACK_DEPTH(STACK_DEPTH)) bus ();

    fetch_seq #(.PC_W(PC_W), .JT_DEPTH(JT_DEPTH), .STACK_DEPTH(STACK_DEPTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic compare(input string nm, input logic [7:0] epc, input logic ed,
                           input logic ee, input logic [2:0] edp);
        n_chk++;
        if (bus.PC === epc && bus.Done === ed && bus.StkErr === ee && bus.Depth === edp)
            n_pass++;
        else
            $display("FAIL %s @cyc %0d: got pc=%02h done=%b err=%b depth=%0d, want pc=%02h done=%b err=%b depth=%0d",
                     nm, cyc, bus.PC, bus.Done, bus.StkErr, bus.Depth, epc, ed, ee, edp);
    endtask

    // Monitor: the DUT presents a new state after every rising edge.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            compare(e.nm, e.pc, e.done, e.err, e.depth);
        end
    end

    task automatic jtw(input int a, input int d);
        bus.JtWen   = 1'b1;
        bus.JtWaddr = JP_W'(a);
        bus.JtWdat  = 8'(d);
    endtask

    task automatic step(input logic [6:0] ctl, input int jp, input logic [7:0] epc,
                        input logic ed, input logic ee, input logic [2:0] edp, input string nm);
        exp_t e;
        {bus.Stall, bus.Jen, bus.Zero, bus.Uncond, bus.Call, bus.Ret, bus.Halt} = ctl;
        bus.Jptr = JP_W'(jp);
        e.cyc = cyc + 1; e.nm = nm; e.pc = epc; e.done = ed; e.err = ee; e.depth = edp;
        q.push_back(e);
        @(negedge Clk);
        bus.JtWen = 1'b0;
    endtask

    initial begin
        {bus.Stall, bus.Jen, bus.Zero, bus.Uncond, bus.Call, bus.Ret, bus.Halt} = '0;
        bus.Jptr = '0; bus.JtWen = 1'b0; bus.JtWaddr = '0; bus.JtWdat = '0;
        @(negedge Clk);
        step(IDLE, 0, 8'h00, 0, 0, 0, "reset0");
        step(IDLE, 0, 8'h00, 0, 0, 0, "reset1");
        Reset = 1'b1;
        for (int k = 1; k <= 260; k++) step(IDLE, 0, 8'(k), 0, 0, 0, "count");

`ifndef FETCH_REL_JUMP_EN
        jtw(3, 'h40); step(IDLE, 0, 8'h05, 0, 0, 0, "seq");
        jtw(1, 'h80); step(IDLE, 0, 8'h06, 0, 0, 0, "seq");
        jtw(4, 'h05); step(IDLE, 0, 8'h07, 0, 0, 0, "seq");
        jtw(5, 'h22); step(IDLE, 0, 8'h08, 0, 0, 0, "seq");
        for (int k = 9; k <= 16; k++) step(IDLE, 0, 8'(k), 0, 0, 0, "seq");
        step(JEN,        3, 8'h11, 0, 0, 0, "jen_z0");
        step(JEN | ZERO, 3, 8'h40, 0, 0, 0, "jen_z1");
        step(JEN | UNC,  3, 8'h40, 0, 0, 0, "jen_unc");
        jtw(3, 'h50); step(JEN | ZERO, 3, 8'h40, 0, 0, 0, "wr_rd_old");
        step(JEN | ZERO, 3, 8'h50, 0, 0, 0, "wr_rd_new");
        step(JEN | UNC,  4, 8'h05, 0, 0, 0, "jmp_05");
        step(CALL, 1, 8'h80, 0, 0, 1, "call");
        step(IDLE, 0, 8'h81, 0, 0, 1, "in_sub");
        step(IDLE, 0, 8'h82, 0, 0, 1, "in_sub");
        step(RET,  0, 8'h06, 0, 0, 0, "ret");
        step(CALL, 1, 8'h80, 0, 0, 1, "nest1");
        step(CALL, 1, 8'h80, 0, 0, 2, "nest2");
        step(CALL, 1, 8'h80, 0, 0, 3, "nest3");
        step(CALL, 1, 8'h80, 0, 0, 4, "nest4");
        step(CALL, 1, 8'h81, 0, 1, 4, "call_ovf");
        step(RET,  0, 8'h81, 0, 1, 3, "unnest4");
        step(RET,  0, 8'h81, 0, 1, 2, "unnest3");
        step(RET,  0, 8'h81, 0, 1, 1, "unnest2");
        step(RET,  0, 8'h07, 0, 1, 0, "unnest1");
        step(RET,  0, 8'h08, 0, 1, 0, "ret_unf");
        step(CALL, 1, 8'h80, 0, 1, 1, "call2");
        step(CALL | RET, 1, 8'h09, 0, 1, 0, "call_ret");
        step(STALL | CALL, 1, 8'h09, 0, 1, 0, "stall_call");
        step(STALL | CALL, 1, 8'h09, 0, 1, 0, "stall_call");
        jtw(7, 'h70); step(STALL | CALL, 1, 8'h09, 0, 1, 0, "stall_call");
        step(CALL, 1, 8'h80, 0, 1, 1, "call3");
        step(STALL | RET, 0, 8'h80, 0, 1, 1, "stall_ret");
        step(RET, 0, 8'h0A, 0, 1, 0, "ret3");
        step(JEN | UNC, 7, 8'h70, 0, 1, 0, "jt_wr_stall");
        step(JEN | UNC, 5, 8'h22, 0, 1, 0, "jmp_22");
        step(HALT | JEN | UNC | CALL, 1, 8'h22, 1, 1, 0, "halt");
        for (int k = 0; k < 10; k++)
            step((k % 2 == 0) ? (JEN | UNC) : CALL, 1, 8'h22, 1, 1, 0, "done_hold");
        Reset = 1'b0;
        #1 compare("async_rst", 8'h00, 0, 0, 0);
        step(IDLE, 0, 8'h00, 0, 0, 0, "rst_hold");
        Reset = 1'b1;
        step(IDLE, 0, 8'h01, 0, 0, 0, "after_rst");
        step(JEN | UNC, 3, 8'h00, 0, 0, 0, "jt_cleared");
        step(RET, 0, 8'h01, 0, 1, 0, "unf_after_rst");
`else
        jtw(2, 'hFC); step(IDLE, 0, 8'h05, 0, 0, 0, "seq");
        jtw(3, 'hF2); step(IDLE, 0, 8'h06, 0, 0, 0, "seq");
        for (int k = 7; k <= 16; k++) step(IDLE, 0, 8'(k), 0, 0, 0, "seq");
        step(JEN | UNC, 2, 8'h0C, 0, 0, 0, "rel_back");
        jtw(2, 'h05); step(JEN | UNC, 3, 8'hFE, 0, 0, 0, "rel_fwd");
        step(JEN | ZERO, 2, 8'h03, 0, 0, 0, "rel_wrap");
        step(CALL, 2, 8'h08, 0, 0, 1, "rel_call");
        step(RET,  0, 8'h04, 0, 0, 0, "rel_ret");
`endif

        for (int t = 0; t < 20 && q.size() > 0; t++) @(negedge Clk);
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
